// File: rtl/wdt_timer_if.sv
// Register bus between the CPU and the watchdog timer.
// Master drives write strobe/address/data; slave returns readback.
interface wdt_timer_if #(
   parameter int TIMER_W = 32
);
   logic               reg_we;
   logic [1:0]         reg_addr;
   logic [TIMER_W-1:0] reg_wdata;
   logic [TIMER_W-1:0] reg_rdata;

   modport master (
      output reg_we,
      output reg_addr,
      output reg_wdata,
      input  reg_rdata
   );

   modport slave (
      input  reg_we,
      input  reg_addr,
      input  reg_wdata,
      output reg_rdata
   );
endinterface

// File: rtl/wdt_timer.sv
// Watchdog timer: counts while enabled, raises a sticky level
// interrupt when the count reaches WTOCNT unless kicked first.
module wdt_timer #(
   parameter int TIMER_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   wdt_timer_if.slave     bus,
   output logic           WDT_interrupt
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COUNT   = 2'd1,
      S_TIMEOUT = 2'd2
   } state_e;

   localparam logic [1:0] A_WDEN   = 2'd0;
   localparam logic [1:0] A_WDLIVE = 2'd1;
   localparam logic [1:0] A_WTOCNT = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   state_e             state_q, state_d;
   logic [TIMER_W-1:0] cnt_q, cnt_d;
   logic [TIMER_W-1:0] wtocnt_q, wtocnt_d;
   logic               wden_q, wden_d;
   logic               irq_q, irq_d;

   logic wr_wden;
   logic wr_wtocnt;
   logic kick;
   logic dis;
   logic en;
   logic expired;

   assign wr_wden   = bus.reg_we && (bus.reg_addr == A_WDEN);
   assign wr_wtocnt = bus.reg_we && (bus.reg_addr == A_WTOCNT);
   assign kick      = bus.reg_we && (bus.reg_addr == A_WDLIVE)
                      && bus.reg_wdata[0];
   assign dis       = wr_wden && !bus.reg_wdata[0];
   assign en        = wr_wden && bus.reg_wdata[0];
   // Compare against the live WTOCNT so lowering it times out promptly.
   assign expired   = (cnt_q >= wtocnt_q);

   always_comb begin
      wden_d   = wden_q;
      wtocnt_d = wtocnt_q;
      if (wr_wden) begin
         wden_d = bus.reg_wdata[0];
      end
      if (wr_wtocnt) begin
         wtocnt_d = bus.reg_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (en) begin
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            if (dis) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (kick) begin
               cnt_d = '0;
            end else if (expired) begin
               state_d = S_TIMEOUT;
            end else begin
               cnt_d = cnt_q + TIMER_W'(1);
            end
         end
         S_TIMEOUT: begin
            if (dis) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (kick) begin
               state_d = S_COUNT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      irq_d = (state_d == S_TIMEOUT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         wden_q   <= 1'b0;
         wtocnt_q <= '1;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wden_q   <= wden_d;
         wtocnt_q <= wtocnt_d;
         irq_q    <= irq_d;
      end
   end

   assign WDT_interrupt = irq_q;

   always_comb begin
      bus.reg_rdata = '0;
      unique case (bus.reg_addr)
         A_WDEN:   bus.reg_rdata = {{(TIMER_W-1){1'b0}}, wden_q};
         A_WDLIVE: bus.reg_rdata = '0;
         A_WTOCNT: bus.reg_rdata = wtocnt_q;
         A_STATUS: bus.reg_rdata = {{(TIMER_W-2){1'b0}}, state_q};
         default:  bus.reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_wdt_timer.sv
// Directed bench for wdt_timer: vector table plus hand sequences
// for WTOCNT lowering, zero timeout and asynchronous reset.
module tb_wdt_timer;

   localparam int W = 32;

   logic clk;
   logic rst;
   logic irq;

   wdt_timer_if #(.TIMER_W(W)) bus ();

   wdt_timer #(.TIMER_W(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .WDT_interrupt (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         we;
      logic [1:0]   addr;
      logic [W-1:0] wdata;
      logic [1:0]   exp_st;
      logic         exp_irq;
   } vec_t;

   vec_t vq[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic we, input logic [1:0] addr,
                       input logic [W-1:0] wdata);
      @(negedge clk);
      bus.reg_we    = we;
      bus.reg_addr  = addr;
      bus.reg_wdata = wdata;
      @(posedge clk);
      #1;
      bus.reg_we = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'd0, '0);
   endtask

   task automatic rd(input string nm, input logic [1:0] addr,
                     input logic [W-1:0] exp);
      bus.reg_addr = addr;
      #1;
      chk(nm, bus.reg_rdata, exp);
   endtask

   task automatic chk_st(input string nm, input logic [1:0] st,
                         input logic ir);
      rd({nm, "_status"}, 2'd3, {{(W-2){1'b0}}, st});
      chk({nm, "_irq"}, {{(W-1){1'b0}}, irq}, {{(W-1){1'b0}}, ir});
   endtask

   function automatic void add(input logic we, input logic [1:0] a,
                               input logic [W-1:0] d,
                               input logic [1:0] st, input logic ir);
      vec_t v;
      v.we = we; v.addr = a; v.wdata = d;
      v.exp_st = st; v.exp_irq = ir;
      vq.push_back(v);
   endfunction

   function automatic void add_idle(input int n, input logic [1:0] st);
      for (int k = 0; k < n; k++) add(1'b0, 2'd0, '0, st, 1'b0);
   endfunction

   initial begin
      // WTOCNT=5, writes that must not start counting
      add(1, 2'd2, 32'd5, 2'd0, 0);
      add(1, 2'd1, 32'd1, 2'd0, 0);
      add(1, 2'd3, 32'd3, 2'd0, 0);
      // basic timeout: enable at E, TIMEOUT after E+6
      add(1, 2'd0, 32'd1, 2'd1, 0);
      add_idle(5, 2'd1);
      add(0, 2'd0, '0, 2'd2, 1);
      add(0, 2'd0, '0, 2'd2, 1);
      add(0, 2'd0, '0, 2'd2, 1);
      // WDEN=1 again in TIMEOUT changes nothing
      add(1, 2'd0, 32'd1, 2'd2, 1);
      // kick clears to COUNT at K
      add(1, 2'd1, 32'd1, 2'd1, 0);
      add_idle(3, 2'd1);
      // kick at K+4, timeout at K+10
      add(1, 2'd1, 32'd1, 2'd1, 0);
      add_idle(5, 2'd1);
      add(0, 2'd0, '0, 2'd2, 1);
      // WDLIVE with bit0=0 is not a kick
      add(1, 2'd1, 32'd2, 2'd2, 1);
      // kick to J, count to cnt=5, kick on the compare edge
      add(1, 2'd1, 32'd1, 2'd1, 0);
      add_idle(5, 2'd1);
      add(1, 2'd1, 32'd1, 2'd1, 0);
      add_idle(5, 2'd1);
      add(0, 2'd0, '0, 2'd2, 1);
      // disable from TIMEOUT
      add(1, 2'd0, 32'd0, 2'd0, 0);
      add_idle(2, 2'd0);

      bus.reg_we    = 1'b0;
      bus.reg_addr  = 2'd0;
      bus.reg_wdata = '0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_st("reset", 2'd0, 1'b0);
      rd("reset_wtocnt", 2'd2, '1);
      rd("reset_wden", 2'd0, '0);
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      chk_st("post_reset_idle", 2'd0, 1'b0);

      foreach (vq[i]) begin
         step(vq[i].we, vq[i].addr, vq[i].wdata);
         chk_st($sformatf("vec%0d", i), vq[i].exp_st, vq[i].exp_irq);
      end
      rd("wtocnt_kept", 2'd2, 32'd5);
      rd("wden_cleared", 2'd0, '0);

      // lower WTOCNT below cnt
      step(1, 2'd2, 32'd100);
      step(1, 2'd0, 32'd1);
      rd("wden_set", 2'd0, 32'd1);
      rd("wdlive_reads0", 2'd1, '0);
      idle(7);
      chk_st("lower_cnt7", 2'd1, 1'b0);
      step(1, 2'd2, 32'd2);
      chk_st("lower_wr", 2'd1, 1'b0);
      rd("lower_wtocnt", 2'd2, 32'd2);
      idle(1);
      chk_st("lower_to", 2'd2, 1'b1);

      // WTOCNT=0 times out one edge after enable
      step(1, 2'd0, 32'd0);
      step(1, 2'd2, 32'd0);
      chk_st("zero_idle", 2'd0, 1'b0);
      step(1, 2'd0, 32'd1);
      chk_st("zero_en", 2'd1, 1'b0);
      idle(1);
      chk_st("zero_to", 2'd2, 1'b1);

      // async reset mid-TIMEOUT, between edges
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("areset_irq", {{(W-1){1'b0}}, irq}, '0);
      rd("areset_wtocnt", 2'd2, '1);
      rd("areset_status", 2'd3, '0);
      rd("areset_wden", 2'd0, '0);
      @(negedge clk);
      rst = 1'b1;
      idle(4);
      chk_st("areset_stays_idle", 2'd0, 1'b0);
      step(1, 2'd2, 32'd1);
      step(1, 2'd0, 32'd1);
      idle(1);
      chk_st("reenable_cnt1", 2'd1, 1'b0);
      idle(1);
      chk_st("reenable_to", 2'd2, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wdt_timer.md
WDT_TIMER -- requirements
Module: wdt_timer

Interface
REQ-001 SHALL provide parameter: TIMER_W, default 32, width of the timeout register and the counter.
REQ-002 SHALL provide ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- reg_we  input  1  register write strobe, one write per cycle.
- reg_addr  input  2  register select: 0=WDEN, 1=WDLIVE, 2=WTOCNT, 3=STATUS (read-only).
- reg_wdata  input  TIMER_W  write data.
- reg_rdata  output  TIMER_W  combinational readback of the register at reg_addr.
- WDT_interrupt  output  1  registered timeout interrupt to the CPU interrupt controller, level, active-high.

Function
REQ-003 SHALL implement a 3-state FSM: IDLE, COUNT, TIMEOUT; WDT_interrupt SHALL be 1 exactly when state==TIMEOUT.
REQ-004 WDEN write (addr 0) SHALL store reg_wdata[0]; WTOCNT write (addr 2) SHALL store all TIMER_W bits; WDLIVE write (addr 1) with reg_wdata[0]=1 SHALL be a one-cycle kick and SHALL NOT be stored.
REQ-005 Writes with reg_we=1 and addr 3 SHALL be ignored.
REQ-006 IDLE: cnt held at 0; the edge that writes WDEN=1 SHALL move to COUNT with cnt=0.
REQ-007 COUNT, per edge, priority high to low:
- WDEN written 0 -> IDLE, cnt=0;
- kick -> stay COUNT, cnt=0;
- cnt >= WTOCNT -> TIMEOUT, cnt holds;
- otherwise cnt=cnt+1.
REQ-008 With WTOCNT=N held constant and no kick, TIMEOUT SHALL be entered on the (N+1)th edge after the edge entering COUNT.
REQ-009 Comparison SHALL be unsigned cnt >= WTOCNT, evaluated against the current WTOCNT every cycle, so cnt never wraps.
REQ-010 Lowering WTOCNT to a value <= cnt SHALL cause TIMEOUT on the next edge.
REQ-011 WTOCNT=0 SHALL time out one edge after entering COUNT.
REQ-012 TIMEOUT:
- WDEN written 0 -> IDLE, cnt=0;
- kick -> COUNT, cnt=0, WDT_interrupt falls on that edge;
- otherwise stay in TIMEOUT (sticky).
REQ-013 Writing WDEN=1 while in COUNT or TIMEOUT SHALL NOT restart or alter the counter.
REQ-014 A kick while in IDLE SHALL be ignored.
REQ-015 A kick on the same edge where cnt >= WTOCNT SHALL win: cnt=0, state remains COUNT, no interrupt.
REQ-016 Writing WTOCNT SHALL NOT change state or cnt by itself.
REQ-017 reg_rdata SHALL return zero-extended values:
- addr 0: WDEN;
- addr 1: 0;
- addr 2: WTOCNT;
- addr 3: {cnt-independent zeros, state[1:0]} with IDLE=0, COUNT=1, TIMEOUT=2.

Reset
REQ-018 When rst=0, asynchronously and regardless of clk: state=IDLE, cnt=0, WDEN=0, WTOCNT=all ones, WDT_interrupt=0.
REQ-019 Reset asserted mid-COUNT or mid-TIMEOUT SHALL drop WDT_interrupt immediately, without waiting for a clock edge.
REQ-020 After rst deasserts, the block SHALL remain in IDLE until WDEN is written 1.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Basic timeout: WTOCNT=5, then WDEN=1 at edge E -> WDT_interrupt=0 through E+5, =1 after edge E+6, holds indefinitely.
- Kick: WTOCNT=5, WDEN=1 at E, kick at E+4 -> no interrupt; interrupt rises after edge E+10.
- Kick on the compare edge (cnt=5, WTOCNT=5) -> no interrupt; interrupt rises 6 edges later.
- Clear from TIMEOUT: kick -> WDT_interrupt falls after that edge, STATUS reads 1; separately, WDEN=0 -> STATUS reads 0, cnt=0.
- Lower WTOCNT to 2 while cnt=7 -> TIMEOUT after the next edge; WTOCNT=0 -> TIMEOUT one edge after enable.
- Async reset: rst=0 mid-TIMEOUT between edges -> WDT_interrupt=0 immediately; WTOCNT reads all ones, STATUS reads 0.
